// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_pkg
// Brief    : Shared mode constants and FSM state encoding for prio_enc_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage : prio_enc_pkg
`default_nettype wire

// File: rtl/prio_enc_core.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_core
// Brief    : Combinational priority encoder, highest set index wins.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc_core #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] in_i,
    output logic         found_o,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o
);

    // Ascending scan: the last set bit seen overwrites earlier ones.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (in_i[i]) begin
                found_o     = 1'b1;
                idx_o       = W'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule : prio_enc_core
`default_nettype wire

// File: rtl/prio_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_arbiter
// Brief    : Registered N-way priority/round-robin arbiter with valid/ready out.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc_arbiter
    import prio_enc_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         any_req
);

    state_e         state_q;
    logic           out_valid_q;
    logic [W-1:0]   out_idx_q;
    logic [N-1:0]   out_onehot_q;

    logic           w_full_found;
    logic [W-1:0]   w_full_idx;
    logic [N-1:0]   w_full_onehot;
    logic [W-1:0]   w_win_idx;
    logic [N-1:0]   w_win_onehot;

    assign any_req    = |req;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;

    prio_enc_core #(.N(N), .W(W)) u_core_full (
        .in_i     (req),
        .found_o  (w_full_found),
        .idx_o    (w_full_idx),
        .onehot_o (w_full_onehot)
    );

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [W-1:0] rr_ptr_q;
            logic [W-1:0] rr_ptr_d;
            logic [N-1:0] w_mask_req;
            logic         w_mask_found;
            logic [W-1:0] w_mask_idx;
            logic [N-1:0] w_mask_onehot;

            // A load coinciding with an accept must already see the advanced
            // pointer, otherwise the just-served requester would win again.
            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (out_valid_q && out_ready) begin
                    rr_ptr_d = (out_idx_q == '0) ? W'(N - 1) : out_idx_q - W'(1);
                end
            end

            always_comb begin
                w_mask_req = '0;
                for (int i = 0; i < N; i++) begin
                    w_mask_req[i] = req[i] & (i <= int'(rr_ptr_d));
                end
            end

            prio_enc_core #(.N(N), .W(W)) u_core_mask (
                .in_i     (w_mask_req),
                .found_o  (w_mask_found),
                .idx_o    (w_mask_idx),
                .onehot_o (w_mask_onehot)
            );

            assign w_win_idx    = w_mask_found ? w_mask_idx    : w_full_idx;
            assign w_win_onehot = w_mask_found ? w_mask_onehot : w_full_onehot;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr_q <= W'(N - 1);
                end else begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end
        end else begin : g_fixed
            assign w_win_idx    = w_full_idx;
            assign w_win_onehot = w_full_onehot;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_full_found) begin
                        state_q      <= ST_HOLD;
                        out_valid_q  <= 1'b1;
                        out_idx_q    <= w_win_idx;
                        out_onehot_q <= w_win_onehot;
                    end
                end
                ST_HOLD: begin
                    // Grant is sticky until accepted; req is ignored meanwhile.
                    if (out_ready) begin
                        if (w_full_found) begin
                            out_valid_q  <= 1'b1;
                            out_idx_q    <= w_win_idx;
                            out_onehot_q <= w_win_onehot;
                        end else begin
                            state_q      <= ST_IDLE;
                            out_valid_q  <= 1'b0;
                            out_idx_q    <= '0;
                            out_onehot_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule : prio_enc_arbiter
`default_nettype wire

// File: tb/tb_prio_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_enc_arbiter
// Brief    : Self-checking bench: N=4 fixed, N=4 round-robin, N=64 round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_enc_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req4;
    logic [63:0] req64;
    logic        rdy;

    logic        v0, v1, v2;
    logic [1:0]  i0, i1;
    logic [5:0]  i2;
    logic [3:0]  oh0, oh1;
    logic [63:0] oh2;
    logic        a0, a1, a2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_enc_arbiter #(.N(4), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req4), .out_valid(v0), .out_ready(rdy),
        .out_idx(i0), .out_onehot(oh0), .any_req(a0)
    );

    prio_enc_arbiter #(.N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .out_valid(v1), .out_ready(rdy),
        .out_idx(i1), .out_onehot(oh1), .any_req(a1)
    );

    prio_enc_arbiter #(.N(64), .MODE(1)) u_rr64 (
        .clk(clk), .rst_n(rst_n), .req(req64), .out_valid(v2), .out_ready(rdy),
        .out_idx(i2), .out_onehot(oh2), .any_req(a2)
    );

    function automatic int nof(int d);
        return (d == 2) ? 64 : 4;
    endfunction

    function automatic int modeof(int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic logic [63:0] reqv(int d);
        return (d == 2) ? req64 : {60'd0, req4};
    endfunction

    function automatic logic dv(int d);
        case (d)
            0:       return v0;
            1:       return v1;
            default: return v2;
        endcase
    endfunction

    function automatic int di(int d);
        case (d)
            0:       return int'(i0);
            1:       return int'(i1);
            default: return int'(i2);
        endcase
    endfunction

    function automatic logic [63:0] doh(int d);
        case (d)
            0:       return {60'd0, oh0};
            1:       return {60'd0, oh1};
            default: return oh2;
        endcase
    endfunction

    function automatic logic da(int d);
        case (d)
            0:       return a0;
            1:       return a1;
            default: return a2;
        endcase
    endfunction

    // Behavioural model: grant state plus round-robin "last-served" pointer.
    bit m_valid [3];
    int m_idx   [3];
    int m_ptr   [3];

    function automatic int pick(logic [63:0] r, int n, int mode, int ptr);
        if (mode == 0) begin
            for (int j = n - 1; j >= 0; j--) if (r[j]) return j;
        end else begin
            for (int k = 0; k < n; k++) begin
                int j;
                j = (ptr - k + n) % n;
                if (r[j]) return j;
            end
        end
        return 0;
    endfunction

    function automatic int eptr(int d);
        if (m_valid[d] && rdy) return (m_idx[d] + nof(d) - 1) % nof(d);
        return m_ptr[d];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_valid[d] <= 1'b0;
                m_idx[d]   <= 0;
                m_ptr[d]   <= nof(d) - 1;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (!m_valid[d] || rdy) begin
                    if (reqv(d) != 64'd0) begin
                        m_valid[d] <= 1'b1;
                        m_idx[d]   <= pick(reqv(d), nof(d), modeof(d), eptr(d));
                    end else begin
                        m_valid[d] <= 1'b0;
                    end
                end
                if (modeof(d) == 1) m_ptr[d] <= eptr(d);
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("model_valid[%0d]", d), 64'(dv(d)), 64'(m_valid[d]));
                if (m_valid[d]) chk($sformatf("model_idx[%0d]", d), 64'(di(d)), 64'(m_idx[d]));
                chk($sformatf("model_onehot[%0d]", d), doh(d),
                    m_valid[d] ? (64'd1 << m_idx[d]) : 64'd0);
                chk($sformatf("model_anyreq[%0d]", d), 64'(da(d)), 64'(|reqv(d)));
            end
        end
    end

    task automatic lit(string nm, int d, logic ev, int ei);
        chk({nm, "_valid"}, 64'(dv(d)), 64'(ev));
        if (ev) chk({nm, "_idx"}, 64'(di(d)), 64'(ei));
        chk({nm, "_onehot"}, doh(d), ev ? (64'd1 << ei) : 64'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int seq_b2b  [4] = '{3, 1, 3, 1};
    int seq_fair [8] = '{3, 2, 1, 0, 3, 2, 1, 0};
    int seq_wide [4] = '{63, 0, 63, 0};

    initial begin
        rst_n = 1'b0;
        req4  = 4'b0000;
        req64 = 64'd0;
        rdy   = 1'b0;
        #12;
        lit("reset", 0, 1'b0, 0);
        chk("reset_idx", 64'(i0), 64'd0);
        #10;
        rst_n = 1'b1;

        repeat (3) begin
            cyc();
            lit("idle", 0, 1'b0, 0);
            chk("idle_anyreq", 64'(a0), 64'd0);
        end

        req4 = 4'b0110;
        rdy  = 1'b1;
        cyc();
        lit("fixed_0110", 0, 1'b1, 2);
        req4 = 4'b0001;
        cyc();
        lit("fixed_0001", 0, 1'b1, 0);
        req4 = 4'b0000;
        cyc();
        lit("fixed_drain", 0, 1'b0, 0);

        rdy  = 1'b0;
        req4 = 4'b1000;
        cyc();
        lit("stall_load", 0, 1'b1, 3);
        repeat (4) cyc();
        lit("stall_5clk", 0, 1'b1, 3);
        req4 = 4'b0001;
        repeat (2) cyc();
        lit("stall_sticky", 0, 1'b1, 3);
        lit("stall_sticky_rr", 1, 1'b1, 3);
        rdy = 1'b1;
        cyc();
        lit("stall_accept", 0, 1'b1, 0);
        req4 = 4'b0000;
        cyc();
        lit("stall_drain", 0, 1'b0, 0);

        req4 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cyc();
            lit("b2b_fix", 0, 1'b1, 3);
            lit("b2b_rr", 1, 1'b1, seq_b2b[k]);
        end
        req4 = 4'b0000;
        cyc();

        rdy  = 1'b0;
        req4 = 4'b1000;
        cyc();
        lit("prerst", 0, 1'b1, 3);
        rst_n = 1'b0;
        #1;
        lit("async_rst", 0, 1'b0, 0);
        chk("async_rst_idx", 64'(i0), 64'd0);
        lit("async_rst_rr", 1, 1'b0, 0);
        req4 = 4'b0000;
        #1;
        rst_n = 1'b1;
        cyc();
        lit("post_rst", 0, 1'b0, 0);

        req4 = 4'b1111;
        rdy  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            lit("fair_rr", 1, 1'b1, seq_fair[k]);
        end
        req4 = 4'b0000;
        cyc();

        req64 = 64'h8000_0000_0000_0001;
        for (int k = 0; k < 4; k++) begin
            cyc();
            lit("wide_rr", 2, 1'b1, seq_wide[k]);
        end
        req64 = 64'd0;
        cyc();
        cyc();
        lit("wide_drain", 2, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prio_enc_arbiter
`default_nettype wire
